msk_tx_mod: RTL and testbench

MSK baseband modulator and symbol-timing source for the transmit side of the modem. It accepts one data bit per symbol through a valid/ready handshake and emits a continuous-phase carrier phase word at one sample per enabled clock, OSF samples per symbol. A programmable fractional timing offset skews the symbol clock, so the receive timing-recovery loop can be exercised against a drifting transmitter. Sits between the bit source and the phase-to-I/Q LUT / DAC path.

---
 rtl/msk_tx_mod.sv | 180 ++++++++++++++++++
 tb/tb_msk_tx_mod.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/msk_tx_mod.sv
// msk_tx_mod: MSK baseband modulator with a skewable symbol-timing source.
// One data bit per symbol through a valid/ready holding register; emits a
// continuous-phase carrier phase word at one sample per enabled clock.
// Optional feature macro: TX_DIFF_ENC_EN (differential precoder on loaded bits).
module msk_tx_mod #(
  parameter int unsigned OSF    = 20,
  parameter int unsigned INT_W  = 5,
  parameter int unsigned FRAC_W = 27,
  parameter int unsigned OFS_W  = 18,
  parameter int unsigned PH_W   = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    en_i,
  input  logic signed [OFS_W-1:0] ofs_i,
  input  logic                    bit_i,
  input  logic                    bit_val_i,
  output logic                    bit_rdy_o,
  output logic [PH_W-1:0]         phase_o,
  output logic                    sample_val_o,
  output logic                    sym_start_o,
  output logic                    underrun_o
);

  localparam int unsigned TAU_W     = INT_W + FRAC_W;
  localparam int unsigned SUM_W     = TAU_W + 2;
  localparam int unsigned K_W       = $clog2(OSF + 1);
  localparam int unsigned OFS_SH    = FRAC_W - 12;
  localparam int unsigned QUARTER_I = 1 << (PH_W - 2);

  localparam logic signed [SUM_W-1:0] ONE   = SUM_W'(1) << FRAC_W;
  localparam logic signed [SUM_W-1:0] LIMIT = SUM_W'(OSF) << FRAC_W;
  localparam logic [PH_W-1:0]         QUARTER = PH_W'(QUARTER_I);
  localparam logic [PH_W-1:0]         STEP    = PH_W'(QUARTER_I / OSF);
  localparam logic [K_W-1:0]          K_MAX   = K_W'(OSF);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Architectural state
  state_t            state, state_n;
  logic [TAU_W-1:0]  tau, tau_n;
  logic [PH_W-1:0]   base, base_n;
  logic [PH_W-1:0]   phase_n;
  logic [K_W-1:0]    k, k_n;
  logic              dir, dir_n;      // 1: phase advances, 0: phase retards
  logic              full, full_n;
  logic              held, held_n;
  logic              rdy_n;
  logic              sample_val_n;
  logic              sym_start_n;
  logic              underrun_n;

  // Timing accumulator arithmetic
  logic signed [SUM_W-1:0] ofs_step;
  logic signed [SUM_W-1:0] tau_sum;
  logic signed [SUM_W-1:0] tau_wrap;
  logic                    boundary;
  logic                    accept;
  logic                    dir_load;

`ifdef TX_DIFF_ENC_EN
  logic enc, enc_n;
  // Differential precoder: direction follows bit XOR previous encoded bit
  assign dir_load = held ^ enc;
`else
  logic enc_unused;
  // Direct mapping of the held bit to the phase direction
  assign dir_load   = held;
  assign enc_unused = 1'b0;
`endif

  // Sample-clock step: one sample plus the signed fractional skew
  assign ofs_step = SUM_W'(ofs_i) <<< OFS_SH;
  assign tau_sum  = $signed({2'b00, tau}) + ONE + ofs_step;
  assign tau_wrap = tau_sum - LIMIT;
  assign boundary = (tau_sum >= LIMIT);
  assign accept   = bit_val_i && bit_rdy_o;

  // Next-state and registered-output logic
  always_comb begin
    state_n      = state;
    tau_n        = tau;
    base_n       = base;
    phase_n      = phase_o;
    k_n          = k;
    dir_n        = dir;
    full_n       = full;
    held_n       = held;
    sample_val_n = 1'b0;
    sym_start_n  = 1'b0;
    underrun_n   = 1'b0;
`ifdef TX_DIFF_ENC_EN
    enc_n        = enc;
`endif

    // Holding register fills regardless of the sample enable
    if (accept) begin
      full_n = 1'b1;
      held_n = bit_i;
    end

    case (state)
      IDLE: if (en_i && (accept || full)) state_n = RUN;
      RUN:  state_n = RUN;
      default: state_n = IDLE;
    endcase

    if (en_i) begin
      sample_val_n = 1'b1;
      if (boundary) begin
        tau_n       = TAU_W'(tau_wrap);
        base_n      = dir ? (base + QUARTER) : (base - QUARTER);
        phase_n     = base_n;
        k_n         = '0;
        sym_start_n = 1'b1;
        if (full) begin
          // Register is full, so nothing was accepted this cycle
          full_n = 1'b0;
          dir_n  = dir_load;
`ifdef TX_DIFF_ENC_EN
          enc_n  = dir_load;
`endif
        end else begin
          dir_n      = 1'b1;
          underrun_n = (state == RUN);
        end
      end else begin
        tau_n = tau_sum[SUM_W-1] ? '0 : TAU_W'(tau_sum);
        // Long symbols hold at the full quarter-cycle ramp
        if (k < K_MAX) begin
          k_n     = k + K_W'(1);
          phase_n = dir ? (phase_o + STEP) : (phase_o - STEP);
        end
      end
    end

    rdy_n = !full_n;
  end

  // State and output registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      tau          <= '0;
      base         <= '0;
      k            <= '0;
      dir          <= 1'b1;
      full         <= 1'b0;
      held         <= 1'b0;
      phase_o      <= '0;
      sample_val_o <= 1'b0;
      sym_start_o  <= 1'b0;
      underrun_o   <= 1'b0;
      bit_rdy_o    <= 1'b0;
`ifdef TX_DIFF_ENC_EN
      enc          <= 1'b0;
`endif
    end else begin
      state        <= state_n;
      tau          <= tau_n;
      base         <= base_n;
      k            <= k_n;
      dir          <= dir_n;
      full         <= full_n;
      held         <= held_n;
      phase_o      <= phase_n;
      sample_val_o <= sample_val_n;
      sym_start_o  <= sym_start_n;
      underrun_o   <= underrun_n;
      bit_rdy_o    <= rdy_n;
`ifdef TX_DIFF_ENC_EN
      enc          <= enc_n;
`endif
    end
  end

endmodule

// File: tb/tb_msk_tx_mod.sv
// tb_msk_tx_mod: directed self-checking bench for msk_tx_mod (default build).
module tb_msk_tx_mod;

  localparam int Q    = 16384;
  localparam int STEP = 819;
  localparam int MODV = 65536;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               en_i;
  logic signed [17:0] ofs_i;
  logic               bit_i;
  logic               bit_val_i;
  logic               bit_rdy_o;
  logic [15:0]        phase_o;
  logic               sample_val_o;
  logic               sym_start_o;
  logic               underrun_o;

  int   n_tests = 0;
  int   n_fail  = 0;
  logic bq[$];

  msk_tx_mod dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .en_i        (en_i),
    .ofs_i       (ofs_i),
    .bit_i       (bit_i),
    .bit_val_i   (bit_val_i),
    .bit_rdy_o   (bit_rdy_o),
    .phase_o     (phase_o),
    .sample_val_o(sample_val_o),
    .sym_start_o (sym_start_o),
    .underrun_o  (underrun_o)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  // Global time limit
  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input int idx, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s[%0d]: observed %0d expected %0d", tag, idx, obs, exp);
    end
  endtask

  task automatic drive();
    bit_val_i = (bq.size() != 0);
    bit_i     = (bq.size() != 0) ? bq[0] : 1'b0;
  endtask

  // One clock; pops the queued bit if the DUT accepted it at this edge
  task automatic cyc();
    logic take;
    take = bit_val_i && bit_rdy_o && reset_n;
    @(negedge clk);
    if (take) void'(bq.pop_front());
    drive();
  endtask

  task automatic do_reset();
    bq.delete();
    drive();
    reset_n = 1'b0;
    en_i    = 1'b1;
    ofs_i   = '0;
    repeat (3) cyc();
    reset_n = 1'b1;
  endtask

  initial begin
    int base;
    int dir;
    int exp_ph;
    int nsym;
    int last;
    int sp;
    int n200;
    int prev_ph;
    int bases_b[4];
    int dirs_b[4];

    bit_i     = 1'b0;
    bit_val_i = 1'b0;
    reset_n   = 1'b0;
    en_i      = 1'b0;
    ofs_i     = '0;

    // Reset values
    do_reset();
    check("rst_phase", 0, 32'(phase_o), 0);
    check("rst_val",   0, 32'(sample_val_o), 0);
    check("rst_sym",   0, 32'(sym_start_o), 0);
    check("rst_und",   0, 32'(underrun_o), 0);
    check("rst_rdy",   0, 32'(bit_rdy_o), 0);

    // Continuous ones: boundaries every 20 samples, +819 ramps
    for (int i = 0; i < 10; i++) bq.push_back(1'b1);
    drive();
    base = 0;
    for (int n = 1; n <= 80; n++) begin
      cyc();
      if (n == 1) check("a_rdy", n, 32'(bit_rdy_o), 1);
      check("a_val", n, 32'(sample_val_o), 1);
      check("a_und", n, 32'(underrun_o), 0);
      if (n % 20 == 0) begin
        base = (base + Q) % MODV;
        check("a_sym",   n, 32'(sym_start_o), 1);
        check("a_start", n, 32'(phase_o), 32'(base));
      end else begin
        check("a_sym",   n, 32'(sym_start_o), 0);
        check("a_ramp",  n, 32'(phase_o), 32'((base + (n % 20) * STEP) % MODV));
      end
    end

    // Alternating bits 0,1,0,1: starts alternate 16384/0, ramps +-819
    do_reset();
    bq.push_back(1'b0); bq.push_back(1'b1); bq.push_back(1'b0);
    bq.push_back(1'b1); bq.push_back(1'b0); bq.push_back(1'b1);
    drive();
    bases_b = '{16384, 0, 16384, 0};
    dirs_b  = '{-1, 1, -1, 1};
    base = 0;
    dir  = 1;
    for (int n = 1; n <= 80; n++) begin
      cyc();
      check("b_und", n, 32'(underrun_o), 0);
      if (n % 20 == 0) begin
        base = bases_b[n / 20 - 1];
        dir  = dirs_b[n / 20 - 1];
        check("b_sym",   n, 32'(sym_start_o), 1);
        check("b_start", n, 32'(phase_o), 32'(base));
      end else begin
        exp_ph = (base + dir * (n % 20) * STEP + MODV) % MODV;
        check("b_ramp", n, 32'(phase_o), 32'(exp_ph));
      end
    end

    // Fast transmitter (+205): spacing 19/20, 200th start at sample 3810
    do_reset();
    ofs_i = 18'sd205;
    nsym  = 0;
    last  = 0;
    n200  = -1;
    for (int n = 1; n <= 4200; n++) begin
      cyc();
      check("c_und_idle", n, 32'(underrun_o), 0);
      if (sym_start_o) begin
        nsym++;
        sp = n - last;
        last = n;
        check("c_spacing", nsym, 32'(sp == 19 || sp == 20), 1);
        if (nsym == 200) begin
          n200 = n;
          break;
        end
      end
    end
    check("c_n200", 200, 32'(n200), 3810);

    // Slow transmitter (-205): spacing 21/22, k=20 holds base+16380
    do_reset();
    ofs_i   = -18'sd205;
    nsym    = 0;
    last    = 0;
    prev_ph = 0;
    for (int n = 1; n <= 600; n++) begin
      cyc();
      if (n == 20 || n == 21) check("d_hold", n, 32'(phase_o), 16380);
      if (sym_start_o) begin
        nsym++;
        sp = n - last;
        last = n;
        check("d_spacing", nsym, 32'(sp == 21 || sp == 22), 1);
        check("d_start",   nsym, 32'(phase_o), 32'((nsym * Q) % MODV));
        check("d_pre",     nsym, 32'(prev_ph), 32'(((nsym - 1) * Q + 16380) % MODV));
        if (nsym == 20) break;
      end
      prev_ph = int'(phase_o);
    end
    check("d_nsym", 0, 32'(nsym), 20);

    // Three bits then none: underrun at boundaries 4 and 5, +16384 per symbol
    do_reset();
    bq.push_back(1'b1); bq.push_back(1'b1); bq.push_back(1'b1);
    drive();
    for (int n = 1; n <= 100; n++) begin
      cyc();
      if (n % 20 == 0) begin
        check("e_sym",   n, 32'(sym_start_o), 1);
        check("e_start", n, 32'(phase_o), 32'(((n / 20) * Q) % MODV));
        check("e_und",   n, 32'(underrun_o), 32'(n / 20 >= 4));
      end else begin
        check("e_und", n, 32'(underrun_o), 0);
      end
    end

    // Enable low mid-symbol: frozen phase, handshake still accepts
    do_reset();
    repeat (5) cyc();
    check("f_pre", 5, 32'(phase_o), 32'(5 * STEP));
    en_i = 1'b0;
    bq.push_back(1'b0);
    drive();
    for (int i = 0; i < 10; i++) begin
      cyc();
      check("f_val",    i, 32'(sample_val_o), 0);
      check("f_freeze", i, 32'(phase_o), 32'(5 * STEP));
      check("f_sym",    i, 32'(sym_start_o), 0);
    end
    check("f_rdy_full", 0, 32'(bit_rdy_o), 0);
    en_i = 1'b1;
    for (int j = 6; j <= 20; j++) begin
      cyc();
      check("f_val", j, 32'(sample_val_o), 1);
      if (j < 20) begin
        check("f_ramp", j, 32'(phase_o), 32'(j * STEP));
        check("f_sym",  j, 32'(sym_start_o), 0);
      end else begin
        check("f_start", j, 32'(phase_o), 32'(Q));
        check("f_sym",   j, 32'(sym_start_o), 1);
      end
    end
    cyc();
    check("f_down", 21, 32'(phase_o), 32'(Q - STEP));
    check("f_rdy",  21, 32'(bit_rdy_o), 1);

    // Reset mid-symbol with the register full: held bit discarded
    do_reset();
    bq.push_back(1'b0); bq.push_back(1'b0);
    drive();
    repeat (25) cyc();
    check("g_full", 25, 32'(bit_rdy_o), 0);
    bq.delete();
    drive();
    reset_n = 1'b0;
    cyc();
    check("g_phase", 0, 32'(phase_o), 0);
    check("g_val",   0, 32'(sample_val_o), 0);
    check("g_sym",   0, 32'(sym_start_o), 0);
    check("g_und",   0, 32'(underrun_o), 0);
    check("g_rdy",   0, 32'(bit_rdy_o), 0);
    reset_n = 1'b1;
    repeat (20) cyc();
    check("g_start", 20, 32'(phase_o), 32'(Q));
    check("g_sym",   20, 32'(sym_start_o), 1);
    cyc();
    check("g_after", 21, 32'(phase_o), 32'(Q + STEP));
    check("g_und",   21, 32'(underrun_o), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
